// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ read-only requesters.
// One burst in flight; R beats are steered to the owner and checked against the granted length.
module axi_rd_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned REQ_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_arvalid,
    output logic [NUM_REQ-1:0]                req_arready,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]              req_arlen,
    output logic [AXI_DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]                req_rvalid,
    output logic [NUM_REQ-1:0]                req_rlast,
    input  logic [NUM_REQ-1:0]                req_rready,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic                              m_axi_rvalid,
    input  logic                              m_axi_rlast,
    output logic                              m_axi_rready,
    output logic [REQ_ID_WIDTH-1:0]           grant_id,
    output logic                              busy,
    output logic                              protocol_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state, state_nxt;
    logic [REQ_ID_WIDTH-1:0] rr_ptr;
    logic [REQ_ID_WIDTH-1:0] hi_idx, lo_idx, grant_idx;
    logic                    hit_hi, hit_lo, any_req;
    logic [8:0]              beat_cnt;
    logic                    beat;

    // Two-pass search: lowest requester at or above rr_ptr, else lowest overall (the wrap).
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req_arvalid[i-1]) begin
                hit_lo = 1'b1;
                lo_idx = REQ_ID_WIDTH'(i - 1);
                if (REQ_ID_WIDTH'(i - 1) >= rr_ptr) begin
                    hit_hi = 1'b1;
                    hi_idx = REQ_ID_WIDTH'(i - 1);
                end
            end
        end
        any_req   = hit_lo;
        grant_idx = hit_hi ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_arready   = '0;
        req_rvalid    = '0;
        req_rlast     = '0;
        m_axi_rready  = 1'b0;
        m_axi_arvalid = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ADDR;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (grant_idx == REQ_ID_WIDTH'(i)) begin
                            req_arready[i] = 1'b1;
                        end
                    end
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_id == REQ_ID_WIDTH'(i)) begin
                        m_axi_rready  = req_rready[i];
                        req_rvalid[i] = m_axi_rvalid;
                        req_rlast[i]  = m_axi_rlast;
                    end
                end
                if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign beat      = (state == DATA) && m_axi_rvalid && m_axi_rready;
    assign req_rdata = m_axi_rdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id <= grant_idx;
                beat_cnt <= '0;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_idx == REQ_ID_WIDTH'(i)) begin
                        m_axi_araddr <= req_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        m_axi_arlen  <= req_arlen[i*8 +: 8];
                    end
                end
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 9'd1;
                // rlast must coincide exactly with the final counted beat; either disagreement is an error.
                if (m_axi_rlast != (beat_cnt == {1'b0, m_axi_arlen})) begin
                    protocol_err <= 1'b1;
                end
                if (m_axi_rlast) begin
                    rr_ptr <= (grant_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                       : grant_id + REQ_ID_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_axi_rd_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_arvalid, req_arready;
    logic [NR*AW-1:0]  req_araddr;
    logic [NR*8-1:0]   req_arlen;
    logic [DW-1:0]     req_rdata;
    logic [NR-1:0]     req_rvalid, req_rlast, req_rready;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic              m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]     m_axi_rdata;
    logic              m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [IW-1:0]     grant_id;
    logic              busy, protocol_err;

    axi_rd_arbiter #(
        .NUM_REQ(NR), .REQ_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_rlast(req_rlast),
        .req_rready(req_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
        .grant_id(grant_id), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner<0 means no burst; otherwise address or data phase of owner.
    int          m_owner, m_rr, m_gid, m_beats;
    bit          m_addr_ph, m_err;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_len;

    function automatic int pick();
        for (int k = 0; k < NR; k++) begin
            if (req_arvalid[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_addr_ph = 0; m_rr = 0; m_gid = 0;
            m_addr = '0; m_len = '0; m_beats = 0; m_err = 0;
        end else if (m_owner < 0) begin
            int g;
            g = pick();
            if (g >= 0) begin
                m_owner = g; m_addr_ph = 1; m_gid = g; m_beats = 0;
                m_addr = req_araddr[g*AW +: AW];
                m_len  = req_arlen[g*8 +: 8];
            end
        end else if (m_addr_ph) begin
            if (m_axi_arready) m_addr_ph = 0;
        end else if (m_axi_rvalid && req_rready[m_owner]) begin
            if (m_axi_rlast) begin
                if (m_beats != int'(m_len)) m_err = 1;
                m_rr = (m_owner + 1) % NR;
                m_owner = -1;
            end else begin
                if (m_beats == int'(m_len)) m_err = 1;
                m_beats++;
            end
        end
    end

    logic [NR-1:0] e_arready, e_rvalid, e_rlast;
    logic          e_rready;
    int            grants[$];
    int            rx_cnt[NR];

    always @(negedge clk) begin
        if (rst_n) begin
            e_arready = '0; e_rvalid = '0; e_rlast = '0; e_rready = 1'b0;
            if (m_owner < 0) begin
                int g;
                g = pick();
                if (g >= 0) e_arready[g] = 1'b1;
            end else if (!m_addr_ph) begin
                e_rready          = req_rready[m_owner];
                e_rvalid[m_owner] = m_axi_rvalid;
                e_rlast[m_owner]  = m_axi_rlast;
            end
            chk("req_arready", 64'(req_arready), 64'(e_arready));
            chk("m_axi_arvalid", 64'(m_axi_arvalid), 64'(m_owner >= 0 && m_addr_ph));
            chk("m_axi_araddr", 64'(m_axi_araddr), 64'(m_addr));
            chk("m_axi_arlen", 64'(m_axi_arlen), 64'(m_len));
            chk("m_axi_rready", 64'(m_axi_rready), 64'(e_rready));
            chk("req_rvalid", 64'(req_rvalid), 64'(e_rvalid));
            chk("req_rlast", 64'(req_rlast), 64'(e_rlast));
            chk("req_rdata", 64'(req_rdata), 64'(m_axi_rdata));
            chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("protocol_err", 64'(protocol_err), 64'(m_err));
            for (int i = 0; i < NR; i++) begin
                if (req_arvalid[i] && req_arready[i]) grants.push_back(i);
                if (req_rvalid[i] && req_rready[i]) rx_cnt[i]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
        m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Slave side of one burst: optional AR stall, then nbeats beats, rlast on the last unless suppressed.
    task automatic serve(input int nbeats, input int ar_delay, input bit toggle, input bit no_last);
        int cyc, b;
        cyc = 0;
        while (!m_axi_arvalid && cyc < 20) begin step(); cyc++; end
        chk("arvalid_timeout", 64'(m_axi_arvalid), 64'd1);
        repeat (ar_delay) step();
        m_axi_arready = 1'b1;
        step();
        m_axi_arready = 1'b0;
        b = 0; cyc = 0;
        while (b < nbeats && cyc < 200) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'h00D0 + 64'(b);
            m_axi_rlast  = !no_last && (b == nbeats - 1);
            if (toggle) req_rready = cyc[0] ? 2'b11 : 2'b00;
            #1;
            if (m_axi_rready) b++;
            step();
            cyc++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        chk("beat_timeout", 64'(b), 64'(nbeats));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, r1;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("rst_grant_busy_err", 64'({grant_id, busy, protocol_err, m_axi_arvalid}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single burst from requester 0
        req_arvalid = 2'b01; req_araddr[0 +: AW] = 32'h1000; req_arlen[0 +: 8] = 8'd3;
        req_rready = 2'b01;
        #1 chk("t1_arready_pulse", 64'(req_arready), 64'b01);
        step();
        req_arvalid = 2'b00;
        chk("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("t1_araddr", 64'(m_axi_araddr), 64'h1000);
        chk("t1_arlen", 64'(m_axi_arlen), 64'd3);
        serve(4, 0, 0, 0);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_rx0", 64'(rx_cnt[0]), 64'd4);
        chk("t1_rx1", 64'(rx_cnt[1]), 64'd0);

        // 2: both requesting continuously, single-beat bursts alternate
        do_reset();
        grants.delete();
        req_araddr = {32'h0000_0200, 32'h0000_0100};
        req_arlen  = '0;
        req_rready = 2'b11;
        req_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) serve(1, 0, 0, 0);
        req_arvalid = 2'b00;
        step();
        chk("t2_grant_count", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            chk("t2_g0", 64'(grants[0]), 64'd0);
            chk("t2_g1", 64'(grants[1]), 64'd1);
            chk("t2_g2", 64'(grants[2]), 64'd0);
            chk("t2_g3", 64'(grants[3]), 64'd1);
        end

        // 3: AR stall and toggling rready on requester 1
        n0 = grants.size();
        r1 = rx_cnt[1];
        req_araddr[AW +: AW] = 32'h2000; req_arlen[8 +: 8] = 8'd3;
        req_arvalid = 2'b10;
        step();
        req_arvalid = 2'b00;
        serve(4, 5, 1, 0);
        req_rready = 2'b11;
        chk("t3_single_arready", 64'(grants.size() - n0), 64'd1);
        chk("t3_rx1_beats", 64'(rx_cnt[1] - r1), 64'd4);
        chk("t3_err", 64'(protocol_err), 64'd0);

        // 4a: early rlast
        do_reset();
        req_araddr[0 +: AW] = 32'h3000; req_arlen[0 +: 8] = 8'd3; req_rready = 2'b11;
        req_arvalid = 2'b01;
        step();
        req_arvalid = 2'b00;
        serve(3, 0, 0, 0);
        chk("t4a_err", 64'(protocol_err), 64'd1);
        chk("t4a_idle", 64'(busy), 64'd0);
        repeat (3) step();
        chk("t4a_err_sticky", 64'(protocol_err), 64'd1);
        do_reset();
        chk("t4a_err_cleared", 64'(protocol_err), 64'd0);

        // 4b: missing rlast on final counted beat
        req_araddr[0 +: AW] = 32'h3100; req_arlen[0 +: 8] = 8'd1; req_rready = 2'b11;
        req_arvalid = 2'b01;
        step();
        req_arvalid = 2'b00;
        serve(3, 0, 0, 0);
        chk("t4b_err", 64'(protocol_err), 64'd1);

        // 5: stray beats while idle
        do_reset();
        req_rready = 2'b11;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'hBEEF;
        #1;
        chk("t5_rready", 64'(m_axi_rready), 64'd0);
        chk("t5_rvalid", 64'(req_rvalid), 64'd0);
        repeat (3) step();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        chk("t5_err", 64'(protocol_err), 64'd0);

        // 6: async reset mid-burst, then a fresh grant
        req_araddr[AW +: AW] = 32'h4000; req_arlen[8 +: 8] = 8'd3;
        req_arvalid = 2'b10;
        step();
        req_arvalid = 2'b00;
        serve(2, 0, 0, 1);
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'h00D2;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("t6_rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("t6_rst_ctrl", 64'({grant_id, busy, protocol_err, m_axi_arvalid, m_axi_rready}), 64'd0);
        chk("t6_rst_rvalid", 64'(req_rvalid), 64'd0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_araddr[AW +: AW] = 32'h5000; req_arlen[8 +: 8] = 8'd0; req_rready = 2'b11;
        req_arvalid = 2'b10;
        #1 chk("t6_arready", 64'(req_arready), 64'b10);
        step();
        req_arvalid = 2'b00;
        chk("t6_grant_id", 64'(grant_id), 64'd1);
        chk("t6_araddr", 64'(m_axi_araddr), 64'h5000);
        serve(1, 0, 0, 0);
        chk("t6_done", 64'({busy, protocol_err}), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
